imem_loader: RTL and testbench

Byte-stream programmer for the 1024x18 instruction memory. It accepts framed bytes from the serial receiver over a valid/ready handshake and assembles them into 18-bit instruction words. Each word is written to the instruction memory's write port at consecutive addresses starting from 0. While a load is in progress it holds the processor in reset, and it reports success or failure when the frame ends.

---
 rtl/imem_loader.sv | 236 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Byte-stream programmer for the 1024x18 instruction memory. Framed bytes
// arrive from the serial receiver over a valid/ready handshake, are packed
// three at a time into 18-bit instruction words, and are written to the
// instruction memory at consecutive addresses starting from 0. While a frame
// is being loaded the processor is held in reset. When the frame ends, a
// trailing XOR checksum is compared and a done or error pulse is produced.
//
// Frame: SYNC, CNT_HI, CNT_LO, N x (B2, B1, B0), CHK
//   N    = {CNT_HI[1:0], CNT_LO} + 1            (1..1024)
//   word = {B2[1:0], B1, B0}
//   CHK  = XOR of every byte after SYNC and before CHK
//
// Parameters:
//   AWIDTH  instruction memory address width
//   DWIDTH  instruction word width (the byte packing assumes 18)
//   SYNC    frame start byte
//
// Ports:
//   Clk_In          rising-edge clock
//   Rst_n_In        asynchronous active-low reset
//   Byte_In         incoming byte
//   Byte_Valid_In   Byte_In is valid
//   Byte_Ready_Out  loader can accept a byte (low only in the write cycle)
//   Wr_En_Out       instruction memory write strobe, one cycle per word
//   Wr_Add_Out      write address
//   Wr_Data_Out     write data (holds between writes)
//   Cpu_Hold_Out    processor reset request while a frame is in progress
//   Done_Out        one-cycle pulse, frame checksum matched
//   Err_Out         one-cycle pulse, frame checksum mismatched
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int          AWIDTH = 10,
    parameter int          DWIDTH = 18,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              Clk_In,
    input  logic              Rst_n_In,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid_In,
    output logic              Byte_Ready_Out,
    output logic              Wr_En_Out,
    output logic [AWIDTH-1:0] Wr_Add_Out,
    output logic [DWIDTH-1:0] Wr_Data_Out,
    output logic              Cpu_Hold_Out,
    output logic              Done_Out,
    output logic              Err_Out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_B2,
        ST_B1,
        ST_B0,
        ST_WRITE,
        ST_CHK
    } state_t;

    state_t state;
    state_t state_next;

    logic              accept;

    // The count field in the frame is always 10 bits wide, so the counter
    // needs 11 bits to hold the largest value (1024) regardless of AWIDTH.
    logic [10:0]       words_left;
    logic [1:0]        cnt_hi_bits;
    logic [1:0]        b2_bits;
    logic [7:0]        b1_byte;
    logic [7:0]        run_xor;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              done_q;
    logic              err_q;

    assign accept = Byte_Valid_In && Byte_Ready_Out;

    // State register.
    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the outputs decoded from the state register.
    // Every state except WRITE is ready, so a valid byte alone is enough to
    // advance; this keeps the handshake inputs off the output paths.
    always_comb begin
        state_next     = state;
        Byte_Ready_Out = 1'b1;
        Wr_En_Out      = 1'b0;
        Cpu_Hold_Out   = 1'b1;

        case (state)
            ST_IDLE: begin
                Cpu_Hold_Out = 1'b0;
                if (Byte_Valid_In && (Byte_In == SYNC)) begin
                    state_next = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (Byte_Valid_In) begin
                    state_next = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (Byte_Valid_In) begin
                    state_next = ST_B2;
                end
            end
            ST_B2: begin
                if (Byte_Valid_In) begin
                    state_next = ST_B1;
                end
            end
            ST_B1: begin
                if (Byte_Valid_In) begin
                    state_next = ST_B0;
                end
            end
            ST_B0: begin
                if (Byte_Valid_In) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                Byte_Ready_Out = 1'b0;
                Wr_En_Out      = 1'b1;
                // words_left still counts the word being written this cycle.
                if (words_left == 11'd1) begin
                    state_next = ST_CHK;
                end else begin
                    state_next = ST_B2;
                end
            end
            ST_CHK: begin
                if (Byte_Valid_In) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: count, partial word bytes, running checksum, write
    // address and write data. The write data register is only loaded when a
    // word completes, so it holds steady between writes.
    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) begin
            words_left  <= '0;
            cnt_hi_bits <= '0;
            b2_bits     <= '0;
            b1_byte     <= '0;
            run_xor     <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && (Byte_In == SYNC)) begin
                        run_xor <= '0;
                    end
                end
                ST_CNT_HI: begin
                    if (accept) begin
                        cnt_hi_bits <= Byte_In[1:0];
                        run_xor     <= run_xor ^ Byte_In;
                    end
                end
                ST_CNT_LO: begin
                    if (accept) begin
                        words_left <= {1'b0, cnt_hi_bits, Byte_In} + 11'd1;
                        wr_addr    <= '0;
                        run_xor    <= run_xor ^ Byte_In;
                    end
                end
                ST_B2: begin
                    if (accept) begin
                        b2_bits <= Byte_In[1:0];
                        run_xor <= run_xor ^ Byte_In;
                    end
                end
                ST_B1: begin
                    if (accept) begin
                        b1_byte <= Byte_In;
                        run_xor <= run_xor ^ Byte_In;
                    end
                end
                ST_B0: begin
                    if (accept) begin
                        wr_data <= DWIDTH'({b2_bits, b1_byte, Byte_In});
                        run_xor <= run_xor ^ Byte_In;
                    end
                end
                ST_WRITE: begin
                    // Address wraps naturally past the top; the word counter
                    // ends the frame before a wrapped address is ever used.
                    wr_addr    <= wr_addr + AWIDTH'(1);
                    words_left <= words_left - 11'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Completion pulses. They are registered on the CHK acceptance edge so
    // they line up with the return to IDLE, where the hold drops.
    always_ff @(posedge Clk_In or negedge Rst_n_In) begin
        if (!Rst_n_In) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if ((state == ST_CHK) && accept) begin
                done_q <= (Byte_In == run_xor);
                err_q  <= (Byte_In != run_xor);
            end
        end
    end

    assign Wr_Add_Out  = wr_addr;
    assign Wr_Data_Out = wr_data;
    assign Done_Out    = done_q;
    assign Err_Out     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Byte streams are built as whole
// frames, then parsed by a frame-level reference (walk the byte list, find
// SYNC, read the count, slice out words, XOR the checksum) to label every
// byte with its role and expected word / checksum outcome. A per-cycle
// expectation (ready, write strobe, address, data, hold, done, err) is
// stepped from those labels as bytes are handed over, and every cycle's DUT
// outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int R_NOISE = 0;
    localparam int R_SYNC  = 1;
    localparam int R_CNTHI = 2;
    localparam int R_CNTLO = 3;
    localparam int R_B2    = 4;
    localparam int R_B1    = 5;
    localparam int R_B0    = 6;
    localparam int R_CHK   = 7;

    logic        Clk_In;
    logic        Rst_n_In;
    logic [7:0]  Byte_In;
    logic        Byte_Valid_In;
    logic        Byte_Ready_Out;
    logic        Wr_En_Out;
    logic [9:0]  Wr_Add_Out;
    logic [17:0] Wr_Data_Out;
    logic        Cpu_Hold_Out;
    logic        Done_Out;
    logic        Err_Out;

    imem_loader #(
        .AWIDTH (10),
        .DWIDTH (18),
        .SYNC   (8'hA5)
    ) dut (
        .Clk_In         (Clk_In),
        .Rst_n_In       (Rst_n_In),
        .Byte_In        (Byte_In),
        .Byte_Valid_In  (Byte_Valid_In),
        .Byte_Ready_Out (Byte_Ready_Out),
        .Wr_En_Out      (Wr_En_Out),
        .Wr_Add_Out     (Wr_Add_Out),
        .Wr_Data_Out    (Wr_Data_Out),
        .Cpu_Hold_Out   (Cpu_Hold_Out),
        .Done_Out       (Done_Out),
        .Err_Out        (Err_Out)
    );

    initial Clk_In = 1'b0;
    always #5 Clk_In = ~Clk_In;

    int checks = 0;
    int errors = 0;

    // Byte stream under test and its per-byte labels.
    logic [7:0]  stream  [0:4095];
    int          role    [0:4095];
    logic [17:0] word_at [0:4095];
    bit          good_at [0:4095];
    int          stream_len;

    // Expected outputs for the current cycle.
    bit          exp_write;
    bit          exp_hold;
    bit          exp_done;
    bit          exp_err;
    logic [9:0]  exp_addr;
    logic [17:0] exp_data;

    int writes_seen;
    int done_seen;
    int err_seen;

    task automatic checkSig(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        checkSig("ready", 32'(Byte_Ready_Out), 32'(!exp_write));
        checkSig("wr_en", 32'(Wr_En_Out), 32'(exp_write));
        checkSig("wr_addr", 32'(Wr_Add_Out), 32'(exp_addr));
        checkSig("wr_data", 32'(Wr_Data_Out), 32'(exp_data));
        checkSig("hold", 32'(Cpu_Hold_Out), 32'(exp_hold));
        checkSig("done", 32'(Done_Out), 32'(exp_done));
        checkSig("err", 32'(Err_Out), 32'(exp_err));
        if (Wr_En_Out === 1'b1) writes_seen++;
        if (Done_Out === 1'b1)  done_seen++;
        if (Err_Out === 1'b1)   err_seen++;
    endtask

    task automatic clearSeen();
        writes_seen = 0;
        done_seen   = 0;
        err_seen    = 0;
    endtask

    task automatic resetModel();
        exp_write = 1'b0;
        exp_hold  = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
    endtask

    // Advance the expectation across one clock edge.
    task automatic stepModel(input bit accepted, input int idx);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (exp_write) exp_addr = exp_addr + 10'd1;
        exp_write = 1'b0;
        if (accepted) begin
            case (role[idx])
                R_SYNC:  exp_hold = 1'b1;
                R_CNTLO: exp_addr = '0;
                R_B0: begin
                    exp_write = 1'b1;
                    exp_data  = word_at[idx];
                end
                R_CHK: begin
                    exp_hold = 1'b0;
                    exp_done = good_at[idx];
                    exp_err  = !good_at[idx];
                end
                default: ;
            endcase
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        stream[stream_len] = b;
        stream_len++;
    endtask

    // Build one frame of n words (sequential word i = i, or random), with an
    // optionally corrupted checksum.
    task automatic addFrame(input int n, input bit seq, input bit corrupt);
        logic [9:0]  cnt;
        logic [7:0]  hi, lo, b2, b1, b0, x;
        logic [17:0] w;
        logic [31:0] r;
        cnt = 10'(n - 1);
        r   = $urandom;
        hi  = seq ? {6'b0, cnt[9:8]} : {r[7:2], cnt[9:8]};
        lo  = cnt[7:0];
        pushByte(8'hA5);
        pushByte(hi);
        pushByte(lo);
        x = hi ^ lo;
        for (int i = 0; i < n; i++) begin
            r  = $urandom;
            w  = seq ? 18'(i) : r[17:0];
            r  = $urandom;
            b2 = {r[5:0], w[17:16]};
            b1 = w[15:8];
            b0 = w[7:0];
            pushByte(b2);
            pushByte(b1);
            pushByte(b0);
            x = x ^ b2 ^ b1 ^ b0;
        end
        if (corrupt) begin
            r = $urandom;
            x = x ^ ((r[7:0] == 8'h00) ? 8'h01 : r[7:0]);
        end
        pushByte(x);
    endtask

    task automatic pushTwoWord(input logic [7:0] chk);
        logic [7:0] lit [0:9];
        lit = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'hA1, 8'h01, 8'h00, 8'hE0, 8'h71, chk};
        for (int i = 0; i < 10; i++) pushByte(lit[i]);
    endtask

    // Frame-level reference: label each byte of the stream.
    task automatic planStream();
        int         i;
        int         n;
        logic [7:0] x;
        for (int k = 0; k < stream_len; k++) begin
            role[k]    = R_NOISE;
            word_at[k] = '0;
            good_at[k] = 1'b0;
        end
        i = 0;
        while (i < stream_len) begin
            if (stream[i] != 8'hA5) begin
                i++;
                continue;
            end
            role[i] = R_SYNC;
            i++;
            if (i < stream_len)     role[i]     = R_CNTHI;
            if (i + 1 < stream_len) role[i + 1] = R_CNTLO;
            if (i + 1 >= stream_len) break;
            n = int'({stream[i][1:0], stream[i + 1]}) + 1;
            x = stream[i] ^ stream[i + 1];
            i += 2;
            for (int k = 0; k < 3 * n && i < stream_len; k++) begin
                role[i] = (k % 3 == 0) ? R_B2 : (k % 3 == 1) ? R_B1 : R_B0;
                x = x ^ stream[i];
                if (k % 3 == 2) word_at[i] = {stream[i - 2][1:0], stream[i - 1], stream[i]};
                i++;
            end
            if (i < stream_len) begin
                role[i]    = R_CHK;
                good_at[i] = (stream[i] == x);
                i++;
            end
        end
    endtask

    task automatic idleCycle();
        Byte_Valid_In = 1'b0;
        Byte_In       = 8'($urandom);
        @(negedge Clk_In);
        checkOutput();
        @(posedge Clk_In);
        #1;
        stepModel(1'b0, 0);
    endtask

    // Offer one byte until the expectation says it is taken (it is refused
    // only during a write cycle, so this is bounded).
    task automatic sendByte(input int idx);
        bit acc;
        Byte_Valid_In = 1'b1;
        Byte_In       = stream[idx];
        acc           = 1'b0;
        while (!acc) begin
            @(negedge Clk_In);
            checkOutput();
            acc = !exp_write;
            @(posedge Clk_In);
            #1;
            stepModel(acc, idx);
        end
        Byte_Valid_In = 1'b0;
    endtask

    task automatic applyStimulus(input int max_gap, input int count);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(max_gap, 0)) idleCycle();
            sendByte(i);
        end
    endtask

    task automatic doReset();
        Rst_n_In      = 1'b0;
        Byte_Valid_In = 1'b0;
        resetModel();
        #1;
        checkOutput();
        repeat (2) begin
            @(negedge Clk_In);
            checkOutput();
        end
        @(posedge Clk_In);
        #1;
        Rst_n_In = 1'b1;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit corrupt;
        logic [31:0] r;

        Rst_n_In      = 1'b0;
        Byte_Valid_In = 1'b0;
        Byte_In       = 8'h00;
        stream_len    = 0;
        resetModel();
        clearSeen();

        // Reset values held, then unchanged after release.
        $display("[TB] reset check");
        repeat (2) begin
            @(negedge Clk_In);
            checkOutput();
        end
        @(posedge Clk_In);
        #1;
        Rst_n_In = 1'b1;
        repeat (3) idleCycle();

        // Two-word load with good checksum.
        $display("[TB] two-word load");
        stream_len = 0;
        pushTwoWord(8'h32);
        planStream();
        clearSeen();
        applyStimulus(0, stream_len);
        repeat (3) idleCycle();
        checkSig("two_word_writes", 32'(writes_seen), 32'd2);
        checkSig("two_word_done", 32'(done_seen), 32'd1);
        checkSig("two_word_err", 32'(err_seen), 32'd0);

        // Same frame with a bad checksum.
        $display("[TB] bad checksum");
        stream_len = 0;
        pushTwoWord(8'h33);
        planStream();
        clearSeen();
        applyStimulus(0, stream_len);
        repeat (3) idleCycle();
        checkSig("bad_chk_writes", 32'(writes_seen), 32'd2);
        checkSig("bad_chk_done", 32'(done_seen), 32'd0);
        checkSig("bad_chk_err", 32'(err_seen), 32'd1);

        // Idle noise and random valid gaps.
        $display("[TB] idle noise and back-pressure");
        stream_len = 0;
        pushByte(8'h00);
        pushByte(8'hFF);
        pushByte(8'h5A);
        pushTwoWord(8'h32);
        planStream();
        clearSeen();
        applyStimulus(5, stream_len);
        repeat (3) idleCycle();
        checkSig("noise_writes", 32'(writes_seen), 32'd2);
        checkSig("noise_done", 32'(done_seen), 32'd1);

        // Full depth: 1024 words, word i = i.
        $display("[TB] full depth");
        stream_len = 0;
        addFrame(1024, 1'b1, 1'b0);
        planStream();
        clearSeen();
        applyStimulus(0, stream_len);
        repeat (3) idleCycle();
        checkSig("full_writes", 32'(writes_seen), 32'd1024);
        checkSig("full_done", 32'(done_seen), 32'd1);
        checkSig("full_err", 32'(err_seen), 32'd0);

        // Random frames, random sizes, some with corrupted checksums.
        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            r       = $urandom;
            n       = 1 + int'(r[5:0] % 40);
            corrupt = r[8];
            stream_len = 0;
            pushByte((r[23:16] == 8'hA5) ? 8'h00 : r[23:16]);
            addFrame(n, 1'b0, corrupt);
            planStream();
            clearSeen();
            applyStimulus(3, stream_len);
            repeat (3) idleCycle();
            checkSig("rand_writes", 32'(writes_seen), 32'(n));
            checkSig("rand_done", 32'(done_seen), corrupt ? 32'd0 : 32'd1);
            checkSig("rand_err", 32'(err_seen), corrupt ? 32'd1 : 32'd0);
        end

        // Reset after B1 of word 5, then a fresh two-word frame.
        $display("[TB] reset mid-frame");
        stream_len = 0;
        addFrame(8, 1'b0, 1'b0);
        planStream();
        clearSeen();
        applyStimulus(0, 20);
        checkSig("mid_writes_before", 32'(writes_seen), 32'd5);
        clearSeen();
        doReset();
        repeat (4) idleCycle();
        checkSig("mid_writes_after", 32'(writes_seen), 32'd0);
        stream_len = 0;
        pushTwoWord(8'h32);
        planStream();
        clearSeen();
        applyStimulus(2, stream_len);
        repeat (3) idleCycle();
        checkSig("mid_fresh_writes", 32'(writes_seen), 32'd2);
        checkSig("mid_fresh_done", 32'(done_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
